// File: rtl/psg_pkg.sv
// Shared constants and helpers for the SN76489-style sound core.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package psg_pkg;

  // Latch-byte field positions
  localparam int LATCH_BIT = 7;
  localparam int CH_HI     = 6;
  localparam int CH_LO     = 5;
  localparam int TYP_BIT   = 4;

  // Noise shift dividers, in ticks, for rates 0/1/2
  localparam int NOISE_DIV0 = 16;
  localparam int NOISE_DIV1 = 32;
  localparam int NOISE_DIV2 = 64;

  typedef enum logic [1:0] {
    REG_TONE  = 2'd0,
    REG_ATT   = 2'd1,
    REG_NOISE = 2'd2
  } reg_typ_e;

  // Register selected by a channel/type pair; channel 3 type 0 is noise control
  function automatic reg_typ_e reg_typ(input logic [1:0] ch, input logic typ);
    if (typ)             return REG_ATT;
    else if (ch == 2'd3) return REG_NOISE;
    else                 return REG_TONE;
  endfunction

  // 2 dB per step attenuation table, 6-bit amplitude
  function automatic logic [5:0] amp(input logic [3:0] att);
    logic [5:0] a;
    case (att)
      4'd0:    a = 6'd63;
      4'd1:    a = 6'd50;
      4'd2:    a = 6'd40;
      4'd3:    a = 6'd32;
      4'd4:    a = 6'd25;
      4'd5:    a = 6'd20;
      4'd6:    a = 6'd16;
      4'd7:    a = 6'd13;
      4'd8:    a = 6'd10;
      4'd9:    a = 6'd8;
      4'd10:   a = 6'd6;
      4'd11:   a = 6'd5;
      4'd12:   a = 6'd4;
      4'd13:   a = 6'd3;
      4'd14:   a = 6'd3;
      default: a = 6'd0;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/psg_tone.sv
// One square-wave tone channel: period down-counter plus output toggle.
// Latency: output toggles on the tick edge where the counter runs out; periods 0/1 give DC high.
// Backpressure: none; runs freely on the shared tick enable.
module psg_tone import psg_pkg::*; #(
  parameter int FREQ_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tick,
  input  logic [FREQ_W-1:0] period,
  output logic              tone
);

  logic [FREQ_W-1:0] cnt;
  logic              tgl;

  // Count down on each tick; when the count runs out (reaches 0) reload the
  // current period and flip, so a steady period P gives a half-cycle of P ticks.
  // A period write never touches cnt, so the running half-cycle finishes first.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
      tgl <= 1'b0;
    end else if (tick) begin
      if (cnt <= FREQ_W'(1)) begin
        cnt <= period;
        tgl <= ~tgl;
      end else begin
        cnt <= cnt - 1'b1;
      end
    end
  end

  assign tone = (period <= FREQ_W'(1)) ? 1'b1 : tgl;

endmodule

// File: rtl/psg_core.sv
// SN76489-compatible sound core: write decode, tone/noise generators, attenuating mixer, 1st-order sigma-delta DAC.
// Latency: register update 1 cycle after accepted write; mix 1 cycle after channel state; dac_out 1 cycle after mix.
// Backpressure: ready drops for WAIT_CYC cycles after each accepted write; writes while not ready are dropped.
module psg_core import psg_pkg::*; #(
  parameter int N_TONE   = 3,
  parameter int PRESCALE = 16,
  parameter int FREQ_W   = 10,
  parameter int NOISE_W  = 15,
  parameter int WAIT_CYC = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr,
  input  logic [7:0] din,
  output logic       ready,
  output logic [7:0] mix,
  output logic       dac_out,
  output logic [3:0] ch_on
);

  localparam int PS_W = $clog2(PRESCALE);
  localparam int WT_W = $clog2(WAIT_CYC + 1);
  localparam logic [NOISE_W-1:0] LFSR_SEED = {1'b1, {(NOISE_W-1){1'b0}}};

  logic [PS_W-1:0]              ps_cnt;
  logic                         tick;
  logic [WT_W-1:0]              wait_cnt;
  logic                         accept;
  logic                         lat_byte;
  logic [1:0]                   lat_ch;
  logic                         lat_typ;
  logic [1:0]                   cur_ch;
  logic                         cur_typ;
  reg_typ_e                     rtyp;
  logic                         noise_wr;
  logic [3:0][3:0]              att;
  logic [N_TONE-1:0][FREQ_W-1:0] period;
  logic [2:0]                   noise_ctl;
  logic [N_TONE-1:0]            tone;
  logic [2:0]                   tone_ext;
  logic                         src_prev;
  logic                         src_rise;
  logic [5:0]                   nz_cnt;
  logic [5:0]                   div_last;
  logic                         nz_shift;
  logic                         fb;
  logic [NOISE_W-1:0]           lfsr;
  logic [7:0]                   mix_sum;
  logic [8:0]                   acc;

  assign tick     = (ps_cnt == PS_W'(PRESCALE - 1));
  assign ready    = (wait_cnt == '0);
  assign accept   = wr & ready;
  assign lat_byte = din[LATCH_BIT];
  assign cur_ch   = lat_byte ? din[CH_HI:CH_LO] : lat_ch;
  assign cur_typ  = lat_byte ? din[TYP_BIT] : lat_typ;
  assign rtyp     = reg_typ(cur_ch, cur_typ);
  assign noise_wr = accept && (rtyp == REG_NOISE);

  // Tick prescaler and post-write busy counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ps_cnt   <= '0;
      wait_cnt <= '0;
    end else begin
      ps_cnt <= tick ? '0 : ps_cnt + 1'b1;
      if (accept)              wait_cnt <= WT_W'(WAIT_CYC);
      else if (wait_cnt != '0) wait_cnt <= wait_cnt - 1'b1;
    end
  end

  // Write decode: latch bytes retarget and write the low nibble, data bytes use the held target
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lat_ch    <= 2'd0;
      lat_typ   <= 1'b0;
      att       <= {4{4'hF}};
      period    <= '0;
      noise_ctl <= 3'd0;
    end else if (accept) begin
      if (lat_byte) begin
        lat_ch  <= cur_ch;
        lat_typ <= cur_typ;
      end
      case (rtyp)
        REG_ATT:   att[cur_ch] <= din[3:0];
        REG_NOISE: noise_ctl   <= din[2:0];
        default: begin
          for (int i = 0; i < N_TONE; i++) begin
            if (cur_ch == 2'(i)) begin
              if (lat_byte) period[i][3:0]        <= din[3:0];
              else          period[i][FREQ_W-1:4] <= (FREQ_W-4)'(din[5:0]);
            end
          end
        end
      endcase
    end
  end

  for (genvar g = 0; g < N_TONE; g++) begin : g_tone
    psg_tone #(.FREQ_W(FREQ_W)) u_tone (
      .clk    (clk),
      .rst_n  (rst_n),
      .tick   (tick),
      .period (period[g]),
      .tone   (tone[g])
    );
  end

  // Unused tone slots read as silent
  assign tone_ext = 3'(tone);
  assign src_rise = tone[N_TONE-1] & ~src_prev;

  // Noise shift enable: tick divider for rates 0-2, last tone's rising edge for rate 3
  always_comb begin
    div_last = 6'(NOISE_DIV2 - 1);
    case (noise_ctl[1:0])
      2'd0:    div_last = 6'(NOISE_DIV0 - 1);
      2'd1:    div_last = 6'(NOISE_DIV1 - 1);
      default: div_last = 6'(NOISE_DIV2 - 1);
    endcase
    nz_shift = (noise_ctl[1:0] == 2'd3) ? src_rise : (tick && (nz_cnt >= div_last));
    fb       = noise_ctl[2] ? (lfsr[0] ^ lfsr[1]) : lfsr[0];
  end

  // Noise LFSR; a control write reseeds it and restarts the divider, overriding any shift
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      src_prev <= 1'b0;
      nz_cnt   <= '0;
      lfsr     <= LFSR_SEED;
    end else begin
      src_prev <= tone[N_TONE-1];
      if (noise_wr) begin
        nz_cnt <= '0;
        lfsr   <= LFSR_SEED;
      end else begin
        if (tick) nz_cnt <= (nz_cnt >= div_last) ? '0 : nz_cnt + 1'b1;
        if (nz_shift) lfsr <= {fb, lfsr[NOISE_W-1:1]};
      end
    end
  end

  // Attenuated sum of the four channels; max 4*63 fits in 8 bits
  always_comb begin
    mix_sum = '0;
    for (int i = 0; i < 3; i++) begin
      if (tone_ext[i]) mix_sum = mix_sum + {2'b00, amp(att[i])};
    end
    if (lfsr[0]) mix_sum = mix_sum + {2'b00, amp(att[3])};
  end

  // Registered mix and sigma-delta accumulator; the carry bit is the DAC pin
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mix <= '0;
      acc <= '0;
    end else begin
      mix <= mix_sum;
      acc <= {1'b0, acc[7:0]} + {1'b0, mix};
    end
  end

  assign dac_out = acc[8];

  for (genvar g = 0; g < 4; g++) begin : g_on
    assign ch_on[g] = (att[g] != 4'hF);
  end

endmodule

// File: tb/tb_psg_core.sv
// Directed bench for psg_core: reset, attenuation, tone period, handshake, noise, DAC.
// Inputs driven on the falling edge, outputs sampled on the falling edge.
// Every wait on the DUT is bounded and a timeout is reported as a failure.
module tb_psg_core;

  localparam int PRESCALE = 16;
  localparam int WAIT_CYC = 32;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr = 1'b0;
  logic [7:0] din = 8'h00;
  logic       ready;
  logic [7:0] mix;
  logic       dac_out;
  logic [3:0] ch_on;

  int n_checks = 0;
  int n_fail   = 0;

  psg_core #(
    .N_TONE   (3),
    .PRESCALE (PRESCALE),
    .FREQ_W   (10),
    .NOISE_W  (15),
    .WAIT_CYC (WAIT_CYC)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr      (wr),
    .din     (din),
    .ready   (ready),
    .mix     (mix),
    .dac_out (dac_out),
    .ch_on   (ch_on)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    wr    = 1'b0;
    din   = 8'h00;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Called on a falling edge; returns on a falling edge with ready high again
  task automatic write_byte(input logic [7:0] b);
    int guard;
    guard = 0;
    while (!ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    wr  = 1'b1;
    din = b;
    @(negedge clk);
    wr = 1'b0;
    guard = 0;
    while (!ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    n_checks++;
    if (!ready) begin
      n_fail++;
      $display("FAIL write_ready_timeout byte=%h ready=%b required 1", b, ready);
    end
  endtask

  task automatic test_reset_att();
    do_reset();
    @(negedge clk);
    n_checks++; if (ready !== 1'b1)   begin n_fail++; $display("FAIL reset_ready got %b want 1", ready); end
    n_checks++; if (mix !== 8'd0)     begin n_fail++; $display("FAIL reset_mix got %0d want 0", mix); end
    n_checks++; if (dac_out !== 1'b0) begin n_fail++; $display("FAIL reset_dac got %b want 0", dac_out); end
    n_checks++; if (ch_on !== 4'b0000) begin n_fail++; $display("FAIL reset_ch_on got %b want 0000", ch_on); end
    write_byte(8'h9F);
    write_byte(8'hBF);
    write_byte(8'hDF);
    write_byte(8'hFF);
    repeat (3) @(negedge clk);
    n_checks++; if (mix !== 8'd0)      begin n_fail++; $display("FAIL mute_mix got %0d want 0", mix); end
    n_checks++; if (ch_on !== 4'b0000) begin n_fail++; $display("FAIL mute_ch_on got %b want 0000", ch_on); end
    // Attenuation write in cycle T must reach mix at T+2, not earlier
    wr  = 1'b1;
    din = 8'h90;
    @(posedge clk);
    #1;
    wr = 1'b0;
    n_checks++; if (mix !== 8'd0) begin n_fail++; $display("FAIL att_latency_early mix got %0d want 0", mix); end
    @(posedge clk);
    #1;
    n_checks++; if (mix !== 8'd63) begin n_fail++; $display("FAIL att_latency_t2 mix got %0d want 63", mix); end
    @(negedge clk);
    n_checks++; if (ch_on !== 4'b0001) begin n_fail++; $display("FAIL att_ch_on got %b want 0001", ch_on); end
  endtask

  task automatic test_handshake();
    int low_cnt;
    int first_high;
    do_reset();
    @(negedge clk);
    wr  = 1'b1;
    din = 8'h90;
    low_cnt    = 0;
    first_high = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 5) begin
        wr  = 1'b1;
        din = 8'h9F;
      end else begin
        wr = 1'b0;
      end
      if (!ready) low_cnt++;
      else if (first_high == 0) first_high = c;
    end
    wr = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (low_cnt != WAIT_CYC)        begin n_fail++; $display("FAIL hs_low_cycles got %0d want %0d", low_cnt, WAIT_CYC); end
    n_checks++; if (first_high != WAIT_CYC + 1) begin n_fail++; $display("FAIL hs_ready_return got cycle %0d want %0d", first_high, WAIT_CYC + 1); end
    n_checks++; if (ch_on !== 4'b0001)          begin n_fail++; $display("FAIL hs_dropped_ch_on got %b want 0001", ch_on); end
    n_checks++; if (mix !== 8'd63)              begin n_fail++; $display("FAIL hs_dropped_mix got %0d want 63", mix); end
  endtask

  task automatic test_tone_period();
    int tr[4];
    logic [7:0] val[4];
    logic [7:0] prev;
    int n;
    int c;
    do_reset();
    write_byte(8'h8E);
    write_byte(8'h0F);
    write_byte(8'h90);
    n = 0;
    c = 0;
    prev = mix;
    while (n < 4 && c < 20000) begin
      @(negedge clk);
      c++;
      if (mix !== prev) begin
        tr[n]  = c;
        val[n] = mix;
        n++;
        prev = mix;
      end
    end
    n_checks++;
    if (n < 4) begin
      n_fail++;
      $display("FAIL tone_timeout transitions got %0d want 4", n);
    end else begin
      n_checks++; if (tr[2] - tr[1] != 254 * PRESCALE) begin n_fail++; $display("FAIL tone_half_a got %0d want %0d", tr[2] - tr[1], 254 * PRESCALE); end
      n_checks++; if (tr[3] - tr[2] != 254 * PRESCALE) begin n_fail++; $display("FAIL tone_half_b got %0d want %0d", tr[3] - tr[2], 254 * PRESCALE); end
      n_checks++; if (!(val[1] == 8'd0 || val[1] == 8'd63)) begin n_fail++; $display("FAIL tone_level got %0d want 0 or 63", val[1]); end
      n_checks++; if (val[2] !== ((val[1] == 8'd0) ? 8'd63 : 8'd0)) begin n_fail++; $display("FAIL tone_alternate got %0d after %0d", val[2], val[1]); end
    end
    n_checks++; if (ch_on !== 4'b0001) begin n_fail++; $display("FAIL tone_ch_on got %b want 0001", ch_on); end
  endtask

  task automatic test_noise_periodic();
    int c;
    int hi_w;
    int lo_w;
    int gap;
    do_reset();
    write_byte(8'hE0);
    write_byte(8'hF0);
    c = 0;
    while (mix !== 8'd63 && c < 5000) begin @(negedge clk); c++; end
    hi_w = 0;
    while (mix === 8'd63 && hi_w < 400) begin @(negedge clk); hi_w++; end
    lo_w = 0;
    while (mix === 8'd0 && lo_w < 4000) begin @(negedge clk); lo_w++; end
    n_checks++; if (hi_w != 16 * 16 * PRESCALE / 16) begin n_fail++; $display("FAIL noise_high_width got %0d want 256", hi_w); end
    n_checks++; if (lo_w != 14 * 256) begin n_fail++; $display("FAIL noise_low_width got %0d want 3584", lo_w); end
    // Let the high phase pass, sit 1000 cycles into the low phase, then reseed
    hi_w = 0;
    while (mix === 8'd63 && hi_w < 400) begin @(negedge clk); hi_w++; end
    repeat (1000) @(negedge clk);
    wr  = 1'b1;
    din = 8'hE0;
    @(negedge clk);
    wr = 1'b0;
    gap = 0;
    while (mix !== 8'd63 && gap < 5000) begin @(negedge clk); gap++; end
    n_checks++; if (gap < 3550 || gap > 3610) begin n_fail++; $display("FAIL noise_restart_gap got %0d want 3550..3610", gap); end
  endtask

  task automatic test_noise_rate3();
    logic [14:0] model;
    logic        prev_t;
    logic        t;
    logic        n_bit;
    int          c;
    do_reset();
    write_byte(8'hC4);
    write_byte(8'h00);
    write_byte(8'hD0);
    write_byte(8'hF2);
    wr  = 1'b1;
    din = 8'hE7;
    @(negedge clk);
    wr = 1'b0;
    prev_t = (mix >= 8'd63);
    model  = 15'h4000;
    for (int k = 1; k <= 32; k++) begin
      c = 0;
      t = prev_t;
      while (!(t && !prev_t) && c < 400) begin
        prev_t = t;
        @(negedge clk);
        c++;
        t = (mix >= 8'd63);
      end
      n_checks++;
      if (c >= 400) begin
        n_fail++;
        $display("FAIL rate3_edge_timeout shift %0d", k);
        break;
      end
      repeat (2) @(negedge clk);
      model = {model[0] ^ model[1], model[14:1]};
      n_bit = (mix == 8'd40) || (mix == 8'd103);
      if (n_bit !== model[0]) begin
        n_fail++;
        $display("FAIL rate3_seq shift %0d noise got %b want %b (mix=%0d)", k, n_bit, model[0], mix);
      end
      prev_t = (mix >= 8'd63);
    end
  endtask

  task automatic test_dac();
    int ones;
    do_reset();
    write_byte(8'h93);
    write_byte(8'hB3);
    repeat (4) @(negedge clk);
    n_checks++; if (mix !== 8'd64) begin n_fail++; $display("FAIL dac_mix got %0d want 64", mix); end
    ones = 0;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      if (dac_out === 1'b1) ones++;
    end
    n_checks++; if (ones != 64) begin n_fail++; $display("FAIL dac_density got %0d want 64", ones); end
  endtask

  initial begin
    test_reset_att();
    test_handshake();
    test_tone_period();
    test_noise_periodic();
    test_noise_rate3();
    test_dac();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
